// File: rtl/clock_seq_pkg.sv
// Shared types and constants for the PLL clock/reset sequencer.
package clock_seq_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    FILTER,
    RUN,
    FAULT
  } pll_seq_state_t;

  localparam int PLL_RGMII = 0;
  localparam int PLL_SGMII = 1;
  localparam int PLL_RAM   = 2;

  localparam int LOSS_W = 8;

  // Bits needed to count 0..limit-1, never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// One PLL channel: lock synchronizer, reset/lock/filter sequencing FSM,
// retry accounting and saturating lock-loss counter.
module pll_lock_monitor
  import clock_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pll_lock,
  input  logic              i_force_reset,
  output logic              o_pll_rst,
  output logic              o_domain_rst_n,
  output logic              o_fault,
  output logic              o_in_run,
  output logic [LOSS_W-1:0] o_loss_count
);

  localparam int CNT_MAX = (LOCK_TIMEOUT_CYCLES > LOCK_FILTER_CYCLES)
    ? ((LOCK_TIMEOUT_CYCLES > RST_PULSE_CYCLES) ? LOCK_TIMEOUT_CYCLES : RST_PULSE_CYCLES)
    : ((LOCK_FILTER_CYCLES > RST_PULSE_CYCLES) ? LOCK_FILTER_CYCLES : RST_PULSE_CYCLES);
  localparam int CW = cnt_width(CNT_MAX);
  localparam int RW = cnt_width(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FLT_LAST  = CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);

  logic              r_sync1, r_lock_s;
  pll_seq_state_t    r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [RW-1:0]     r_retry, w_retry_nxt, w_retry_inc;
  logic [LOSS_W-1:0] r_loss, w_loss_nxt;
  logic              w_fail;
  logic              r_pll_rst, r_domain_rst_n, r_fault, r_in_run;

  assign w_retry_inc = r_retry + 1'b1;

  // One counter serves as pulse timer, lock timeout and filter run-length;
  // every state that uses it clears it on entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_fail      = 1'b0;
    if (i_force_reset) begin
      w_state_nxt = RESET;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        RESET: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = FILTER;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TO_LAST) begin
            w_fail = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        FILTER: begin
          if (!r_lock_s) begin
            w_fail = 1'b1;
          end else if (r_cnt == FLT_LAST) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!r_lock_s) begin
            w_state_nxt = RESET;
            w_cnt_nxt   = '0;
            if (r_loss != '1) w_loss_nxt = r_loss + 1'b1;
          end
        end
        FAULT: ;
        default: begin
          w_state_nxt = RESET;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_fail) begin
        w_retry_nxt = w_retry_inc;
        w_cnt_nxt   = '0;
        w_state_nxt = (w_retry_inc == RETRY_LIM) ? FAULT : RESET;
      end
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1        <= 1'b0;
      r_lock_s       <= 1'b0;
      r_state        <= RESET;
      r_cnt          <= '0;
      r_retry        <= '0;
      r_loss         <= '0;
      r_pll_rst      <= 1'b1;
      r_domain_rst_n <= 1'b0;
      r_fault        <= 1'b0;
      r_in_run       <= 1'b0;
    end else begin
      r_sync1        <= i_pll_lock;
      r_lock_s       <= r_sync1;
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_retry        <= w_retry_nxt;
      r_loss         <= w_loss_nxt;
      r_pll_rst      <= (w_state_nxt == RESET) || (w_state_nxt == FAULT);
      r_domain_rst_n <= (w_state_nxt == RUN);
      r_fault        <= (w_state_nxt == FAULT);
      r_in_run       <= (w_state_nxt == RUN);
    end
  end

  assign o_pll_rst      = r_pll_rst;
  assign o_domain_rst_n = r_domain_rst_n;
  assign o_fault        = r_fault;
  assign o_in_run       = r_in_run;
  assign o_loss_count   = r_loss;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Sequences reset/lock for the board PLL bank; one independent monitor per
// channel plus a registered all-channels-running flag.
module clock_reset_sequencer
  import clock_seq_pkg::*;
#(
  parameter int NUM_PLLS            = 3,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PLLS-1:0]        pll_lock,
  input  logic [NUM_PLLS-1:0]        force_reset,
  output logic [NUM_PLLS-1:0]        pll_rst,
  output logic [NUM_PLLS-1:0]        domain_rst_n,
  output logic [NUM_PLLS-1:0]        fault,
  output logic                       all_ready,
  output logic [NUM_PLLS*LOSS_W-1:0] loss_count
);

  logic [NUM_PLLS-1:0]             w_in_run;
  logic [NUM_PLLS-1:0][LOSS_W-1:0] w_loss;
  logic                            r_all_ready;

  for (genvar g = 0; g < NUM_PLLS; g++) begin : g_ch
    pll_lock_monitor #(
      .RST_PULSE_CYCLES    (RST_PULSE_CYCLES),
      .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
      .LOCK_FILTER_CYCLES  (LOCK_FILTER_CYCLES),
      .MAX_RETRIES         (MAX_RETRIES)
    ) u_mon (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_pll_lock     (pll_lock[g]),
      .i_force_reset  (force_reset[g]),
      .o_pll_rst      (pll_rst[g]),
      .o_domain_rst_n (domain_rst_n[g]),
      .o_fault        (fault[g]),
      .o_in_run       (w_in_run[g]),
      .o_loss_count   (w_loss[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_all_ready <= 1'b0;
    else        r_all_ready <= &w_in_run;
  end

  assign all_ready  = r_all_ready;
  assign loss_count = w_loss;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed + randomized bench; a deadline-based per-channel reference model
// predicts every output after every clock edge.
module tb_clock_reset_sequencer;

  localparam int NP    = 3;
  localparam int PULSE = 4;
  localparam int TO    = 32;
  localparam int FILT  = 8;
  localparam int MAXR  = 3;

  // Model phases (bench-local numbering).
  localparam int MD_HOLD = 0, MD_WAIT = 1, MD_FILT = 2, MD_RUN = 3, MD_DEAD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] lk = '0;
  logic [NP-1:0] frc = '0;
  logic [NP-1:0] pll_rst, domain_rst_n, fault;
  logic          all_ready;
  logic [NP*8-1:0] loss_count;

  int n_chk = 0, n_fail = 0;

  int        n;             // index of the most recent clock edge
  int        m_mode [NP];
  int        m_dl   [NP];   // edge at which the current timed phase ends
  int        m_fails[NP];
  int        m_loss [NP];
  logic [NP-1:0] ls1, ls2;  // two-edge delay of the lock pins
  logic      e_ar;

  clock_reset_sequencer #(
    .NUM_PLLS(NP), .RST_PULSE_CYCLES(PULSE), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_FILTER_CYCLES(FILT), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(lk), .force_reset(frc),
    .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .fault(fault),
    .all_ready(all_ready), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  task automatic m_enter_hold(input int ch);
    m_mode[ch] = MD_HOLD;
    m_dl[ch]   = n + PULSE;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NP; ch++) begin
      m_enter_hold(ch);
      m_fails[ch] = 0;
      m_loss[ch]  = 0;
    end
    ls1  = '0;
    ls2  = '0;
    e_ar = 1'b0;
  endtask

  task automatic m_attempt_failed(input int ch);
    m_fails[ch]++;
    if (m_fails[ch] == MAXR) m_mode[ch] = MD_DEAD;
    else                     m_enter_hold(ch);
  endtask

  task automatic model_step();
    logic [NP-1:0] ls;
    logic all_run;
    n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls  = ls2;
    ls2 = ls1;
    ls1 = lk;
    all_run = 1'b1;
    for (int ch = 0; ch < NP; ch++) if (m_mode[ch] != MD_RUN) all_run = 1'b0;
    e_ar = all_run;
    for (int ch = 0; ch < NP; ch++) begin
      if (frc[ch]) begin
        m_enter_hold(ch);
        m_fails[ch] = 0;
      end else begin
        case (m_mode[ch])
          MD_HOLD: if (n == m_dl[ch]) begin m_mode[ch] = MD_WAIT; m_dl[ch] = n + TO; end
          MD_WAIT: begin
            if (ls[ch]) begin m_mode[ch] = MD_FILT; m_dl[ch] = n + FILT; end
            else if (n == m_dl[ch]) m_attempt_failed(ch);
          end
          MD_FILT: begin
            if (!ls[ch]) m_attempt_failed(ch);
            else if (n == m_dl[ch]) begin m_mode[ch] = MD_RUN; m_fails[ch] = 0; end
          end
          MD_RUN: if (!ls[ch]) begin
            m_enter_hold(ch);
            if (m_loss[ch] < 255) m_loss[ch]++;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    logic [NP-1:0]   e_prst, e_dom, e_flt;
    logic [NP*8-1:0] e_loss;
    for (int ch = 0; ch < NP; ch++) begin
      e_prst[ch] = (m_mode[ch] == MD_HOLD) || (m_mode[ch] == MD_DEAD);
      e_dom[ch]  = (m_mode[ch] == MD_RUN);
      e_flt[ch]  = (m_mode[ch] == MD_DEAD);
      e_loss[ch*8 +: 8] = 8'(m_loss[ch]);
    end
    chk("pll_rst", 32'(pll_rst), 32'(e_prst));
    chk("domain_rst_n", 32'(domain_rst_n), 32'(e_dom));
    chk("fault", 32'(fault), 32'(e_flt));
    chk("all_ready", 32'(all_ready), 32'(e_ar));
    chk("loss_count", 32'(loss_count), 32'(e_loss));
  endtask

  // Advance cnt edges; force_reset is a one-cycle request.
  task automatic step(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
      frc = '0;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n = 0;
    model_reset();
    // Reset values held while rst_n is low, then release with every lock high.
    lk = '1;
    step(3);
    rst_n = 1'b1;
    step(25);

    // Channel 1 never locks: three timed-out attempts, then FAULT.
    lk = 3'b101;
    pulse_reset();
    step(140);

    // One-cycle lock drop on channel 2 while running.
    lk[2] = 1'b0;
    step(1);
    lk[2] = 1'b1;
    step(30);

    // Channel 0 lock toggles every 5 cycles: filter never completes.
    frc = 3'b001;
    for (int i = 0; i < 30; i++) begin
      lk[0] = ~lk[0];
      step(5);
    end

    // Recover faulted channels by software request with lock present.
    lk  = '1;
    frc = 3'b011;
    step(25);

    // Force coincident with a post-sync lock drop on running channel 2.
    lk[2] = 1'b0;
    step(2);
    frc = 3'b100;
    lk[2] = 1'b1;
    step(25);

    // Repeated lock losses on channel 0 push the counter into saturation.
    for (int i = 0; i < 260; i++) begin
      lk[0] = 1'b0;
      step(1);
      lk[0] = 1'b1;
      step(17);
    end

    // Randomized lock glitches and software requests.
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < NP; ch++) begin
        if ($urandom_range(0, 24) == 0) lk[ch] = ~lk[ch];
        if ($urandom_range(0, 99) == 0) frc[ch] = 1'b1;
      end
      step(1);
    end

    // Asynchronous reset asserted while every channel sits in FILTER.
    lk  = '1;
    frc = '1;
    step(1);
    step(PULSE + 1 + 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(2);
    rst_n = 1'b1;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
